// File: rtl/fsb_bus_ctrl.sv
// fsb_bus_ctrl: front-side-bus transaction engine behind the L2 MESI controller.
// Define FSB_TIMEOUT_EN to build in the ARB/read-data watchdog that aborts with RSP_ERR.
module fsb_bus_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int SNOOP_LAT = 2,
    parameter int BEATS     = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [63:0]       WB_DATA,
    output logic              WB_POP,
    output logic              BUS_REQ,
    input  logic              BUS_GNT,
    output logic              FSB_ADDR_VALID,
    output logic [ADDR_W-1:0] FSB_ADDR,
    output logic [1:0]        FSB_CMD,
    input  logic              FSB_HIT,
    input  logic              FSB_HITM,
    input  logic [63:0]       FSB_DIN,
    input  logic              FSB_DIN_VALID,
    output logic [63:0]       FSB_DOUT,
    output logic              FSB_DOUT_VALID,
    output logic              RSP_BEAT_VALID,
    output logic [63:0]       RSP_DATA,
    output logic              RSP_VALID,
    output logic [1:0]        RSP_HM,
    output logic              RSP_ERR
);
    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_RFO  = 2'd1,
        OP_WB   = 2'd2,
        OP_INV  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_SNOOP,
        S_DATA,
        S_DONE
    } state_e;

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int SNP_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] WB_LAST  = CNT_W'(BEATS - 1);
    localparam logic [SNP_W-1:0] SNP_LAST = SNP_W'(SNOOP_LAT - 1);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        hm_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [SNP_W-1:0]  snp_cnt;
    logic [1:0]        snoop_hm;

    // HITM outranks HIT: a modified copy elsewhere dominates the MESI decision.
    assign snoop_hm = FSB_HITM ? 2'd2 : (FSB_HIT ? 2'd1 : 2'd0);
    assign FSB_DOUT = FSB_DOUT_VALID ? WB_DATA : 64'd0;

`ifdef FSB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_cnt;
    logic            rsp_err;
    assign RSP_ERR = rsp_err;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign RSP_ERR = 1'b0;
`endif

    // NOTE: non-blocking assignments throughout; every output here is a register,
    // so a state decision made at an edge shows up on the pins in the following cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            op_q           <= OP_READ;
            addr_q         <= '0;
            hm_q           <= 2'd0;
            beat_cnt       <= '0;
            snp_cnt        <= '0;
            REQ_READY      <= 1'b1;
            WB_POP         <= 1'b0;
            BUS_REQ        <= 1'b0;
            FSB_ADDR_VALID <= 1'b0;
            FSB_ADDR       <= '0;
            FSB_CMD        <= 2'd0;
            FSB_DOUT_VALID <= 1'b0;
            RSP_BEAT_VALID <= 1'b0;
            RSP_DATA       <= 64'd0;
            RSP_VALID      <= 1'b0;
            RSP_HM         <= 2'd0;
`ifdef FSB_TIMEOUT_EN
            wd_cnt         <= '0;
            rsp_err        <= 1'b0;
`endif
        end else begin
            RSP_BEAT_VALID <= 1'b0;
            RSP_DATA       <= 64'd0;
`ifdef FSB_TIMEOUT_EN
            // Restarts on every state change and every beat; only the wait branches count up.
            wd_cnt         <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        op_q      <= op_e'(REQ_OP);
                        addr_q    <= REQ_ADDR;
                        REQ_READY <= 1'b0;
                        BUS_REQ   <= 1'b1;
                        state     <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (BUS_GNT) begin
                        FSB_ADDR_VALID <= 1'b1;
                        FSB_ADDR       <= addr_q;
                        FSB_CMD        <= op_q;
                        state          <= S_ADDR;
                    end
`ifdef FSB_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        BUS_REQ   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_HM    <= 2'd0;
                        rsp_err   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_ADDR: begin
                    FSB_ADDR_VALID <= 1'b0;
                    FSB_ADDR       <= '0;
                    FSB_CMD        <= 2'd0;
                    beat_cnt       <= '0;
                    snp_cnt        <= '0;
                    if (op_q == OP_WB) begin
                        hm_q           <= 2'd0;
                        FSB_DOUT_VALID <= 1'b1;
                        WB_POP         <= 1'b1;
                        state          <= S_DATA;
                    end else begin
                        state <= S_SNOOP;
                    end
                end
                S_SNOOP: begin
                    if (snp_cnt == SNP_LAST) begin
                        if (op_q == OP_INV) begin
                            BUS_REQ   <= 1'b0;
                            RSP_VALID <= 1'b1;
                            RSP_HM    <= snoop_hm;
                            state     <= S_DONE;
                        end else begin
                            hm_q  <= snoop_hm;
                            state <= S_DATA;
                        end
                    end else begin
                        snp_cnt <= snp_cnt + SNP_W'(1);
                    end
                end
                S_DATA: begin
                    if (op_q == OP_WB) begin
                        if (beat_cnt == WB_LAST) begin
                            FSB_DOUT_VALID <= 1'b0;
                            WB_POP         <= 1'b0;
                            BUS_REQ        <= 1'b0;
                            RSP_VALID      <= 1'b1;
                            RSP_HM         <= hm_q;
                            state          <= S_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end else if (beat_cnt == RD_LAST) begin
                        // One drain cycle lets the last fill beat reach RSP_DATA before the response.
                        BUS_REQ   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_HM    <= hm_q;
                        state     <= S_DONE;
                    end else if (FSB_DIN_VALID) begin
                        RSP_BEAT_VALID <= 1'b1;
                        RSP_DATA       <= FSB_DIN;
                        beat_cnt       <= beat_cnt + CNT_W'(1);
                    end
`ifdef FSB_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        BUS_REQ   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_HM    <= 2'd0;
                        rsp_err   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    RSP_VALID <= 1'b0;
                    RSP_HM    <= 2'd0;
                    beat_cnt  <= '0;
                    REQ_READY <= 1'b1;
                    state     <= S_IDLE;
`ifdef FSB_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/fsb_bus_ctrl.md
Name: fsb_bus_ctrl

Overview:
- Front-side-bus transaction engine directly downstream of the L2 MESI cache controller.
- Accepts one bus request at a time from the controller: READ, RFO (read-for-ownership), WRITEBACK or INVALIDATE.
- Arbitrates for the shared 64-bit FSB, drives the address phase and collects the snoop result (MISS/HIT/HITM).
- Moves a full cache line in 64-bit beats, then returns a one-cycle response carrying the snoop result. The controller uses that result to pick the next MESI state.

Parameters:
- ADDR_W, 32, address width.
- SNOOP_LAT, 2, cycles from address phase to snoop sample (≥1).
- BEATS, 8, 64-bit beats per line (64-byte line, ≥1).
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  asynchronous active-high reset.
- REQ_VALID  in  1  request from MESI controller.
- REQ_READY  out  1  block can accept a request.
- REQ_OP  in  2  0 READ, 1 RFO, 2 WRITEBACK, 3 INVALIDATE.
- REQ_ADDR  in  ADDR_W  line address.
- WB_DATA  in  64  writeback beat, supplied by controller.
- WB_POP  out  1  WB_DATA consumed this cycle; controller advances.
- BUS_REQ  out  1  FSB arbitration request.
- BUS_GNT  in  1  FSB grant.
- FSB_ADDR_VALID  out  1  address phase strobe.
- FSB_ADDR  out  ADDR_W  bus address.
- FSB_CMD  out  2  bus command, same encoding as REQ_OP.
- FSB_HIT  in  1  snoop HIT.
- FSB_HITM  in  1  snoop HITM.
- FSB_DIN  in  64  bus read data.
- FSB_DIN_VALID  in  1  read beat valid.
- FSB_DOUT  out  64  bus write data.
- FSB_DOUT_VALID  out  1  write beat valid.
- RSP_BEAT_VALID  out  1  fill beat valid on RSP_DATA.
- RSP_DATA  out  64  fill beat.
- RSP_VALID  out  1  one-cycle transaction-complete pulse.
- RSP_HM  out  2  0 MISS, 1 HIT, 2 HITM; valid with RSP_VALID.
- RSP_ERR  out  1  transaction aborted; valid with RSP_VALID.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction): state goes to IDLE. All outputs are 0 except REQ_READY=1. Counters and latched op/addr clear. A transaction in flight is dropped and no response is issued.
- States: IDLE, ARB, ADDR, SNOOP, DATA, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY: latch op/addr, go to ARB.
  - REQ_READY=0 in every other state.
- ARB:
  - BUS_REQ=1.
  - BUS_GNT sampled high goes to ADDR next cycle.
  - BUS_REQ stays high from ARB through DATA and drops in DONE.
- ADDR: exactly one cycle of FSB_ADDR_VALID=1 with FSB_ADDR and FSB_CMD driven. FSB_ADDR and FSB_CMD return to 0 outside ADDR.
- SNOOP:
  - Entered after ADDR for READ, RFO and INVALIDATE. WRITEBACK skips it and records HM=0.
  - Lasts SNOOP_LAT cycles. HIT/HITM are sampled on the last cycle only.
  - HITM takes priority over HIT: HM=2 if HITM, else 1 if HIT, else 0.
  - INVALIDATE goes SNOOP→DONE.
- DATA, READ/RFO:
  - Count FSB_DIN_VALID beats. Each beat appears on RSP_DATA with RSP_BEAT_VALID one cycle later (registered).
  - After beat BEATS, go to DONE. Gaps between beats are allowed.
- DATA, WRITEBACK:
  - BEATS consecutive cycles of FSB_DOUT_VALID=1, with FSB_DOUT=WB_DATA and WB_POP=1 in the same cycle.
  - Then go to DONE.
- FSB_DIN_VALID outside DATA, or beyond BEATS, is ignored.
- DONE: RSP_VALID=1 for exactly one cycle with RSP_HM, then IDLE.
- Minimum latency, accept to RSP_VALID: READ = 1 + 1 + SNOOP_LAT + BEATS + 2 cycles with zero-wait grant and back-to-back data.
- Beat counter width is clog2(BEATS+1). It wraps to 0 in DONE.
- Back-to-back requests: a new request can be accepted no earlier than the IDLE cycle after DONE.

Optional Feature:
- Macro: FSB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in ARB, or in DATA on READ/RFO, while waiting. It restarts on each state entry and on each received beat.
  - Reaching TIMEOUT forces DONE: RSP_VALID=1, RSP_ERR=1, RSP_HM=0. Partially delivered beats are not retracted.
- Not defined: no watchdog; the block waits indefinitely; RSP_ERR is tied to 0.

Test Plan:
- READ 0x0000_1000, GNT in the same cycle as BUS_REQ, no snoop hits, 8 back-to-back beats 0..7 → FSB_CMD=0 for exactly 1 cycle; RSP_DATA 0..7 in order; RSP_VALID with RSP_HM=0 at 14 cycles after accept.
- RFO with FSB_HIT=1 and FSB_HITM=1 on the sample cycle → RSP_HM=2. HIT asserted one cycle early, then dropped → RSP_HM=0.
- WRITEBACK with GNT delayed 5 cycles → BUS_REQ held 5 cycles; 8 consecutive FSB_DOUT_VALID cycles, each with WB_POP; no SNOOP cycles; RSP_HM=0.
- INVALIDATE with HIT → no data cycles; RSP_VALID with RSP_HM=1; REQ_READY=1 the cycle after DONE, and a second READ accepted there.
- RST pulsed during DATA beat 3 → outputs clear immediately; no RSP_VALID; a subsequent READ completes normally.
- FSB_TIMEOUT_EN, TIMEOUT=64, GNT never asserted → RSP_VALID with RSP_ERR=1 exactly 64 cycles after ARB entry. Without the macro, no response after 200 cycles.
